// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: mode-0, MSB-first SPI master shared round-robin between two requesters.
module spi_master_arbiter #(
    parameter int unsigned DATA_LENGTH = 8,
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned SS_GAP      = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req0,
    input  logic [DATA_LENGTH-1:0] wdata0,
    output logic [DATA_LENGTH-1:0] rdata0,
    output logic                   done0,
    input  logic                   req1,
    input  logic [DATA_LENGTH-1:0] wdata1,
    output logic [DATA_LENGTH-1:0] rdata1,
    output logic                   done1,
    output logic                   busy,
    output logic                   SCLK,
    output logic                   MOSI,
    input  logic                   MISO,
    output logic                   SS
);

    localparam int unsigned GAP_CLKS = SS_GAP * CLK_DIV;
    localparam int unsigned CNT_MAX  = (GAP_CLKS > CLK_DIV) ? GAP_CLKS : CLK_DIV;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX);
    localparam int unsigned BIT_W    = $clog2(DATA_LENGTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_LENGTH-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_LENGTH-1:0] rx_sr_q, rx_sr_d;
    logic [DATA_LENGTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_LENGTH-1:0] rdata1_q, rdata1_d;
    logic                   last_grant_q, last_grant_d;
    logic                   sclk_q, sclk_d;
    logic                   ss_q, ss_d;
    logic                   mosi_q, mosi_d;
    logic                   busy_q, busy_d;
    logic                   done0_q, done0_d;
    logic                   done1_q, done1_d;
    logic                   miso_s1, miso_s2;
    logic                   pick;
    logic                   half_done;
    logic                   gap_done;
    logic [DATA_LENGTH-1:0] wsel;

    // Two-flop synchronizer for the asynchronous MISO line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso_s1 <= 1'b0;
            miso_s2 <= 1'b0;
        end else begin
            miso_s1 <= MISO;
            miso_s2 <= miso_s1;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            tx_sr_q      <= '0;
            rx_sr_q      <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            last_grant_q <= 1'b1;
            sclk_q       <= 1'b0;
            ss_q         <= 1'b1;
            mosi_q       <= 1'b0;
            busy_q       <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            tx_sr_q      <= tx_sr_d;
            rx_sr_q      <= rx_sr_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            last_grant_q <= last_grant_d;
            sclk_q       <= sclk_d;
            ss_q         <= ss_d;
            mosi_q       <= mosi_d;
            busy_q       <= busy_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
        end
    end

    // Next-state, arbitration and shift control
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_cnt_d    = bit_cnt_q;
        tx_sr_d      = tx_sr_q;
        rx_sr_d      = rx_sr_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        last_grant_d = last_grant_q;
        sclk_d       = sclk_q;
        ss_d         = ss_q;
        mosi_d       = mosi_q;
        busy_d       = busy_q;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        // requester 1 wins when alone, or on a tie when requester 0 went last
        pick         = req1 & (~req0 | ~last_grant_q);
        wsel         = pick ? wdata1 : wdata0;
        half_done    = (cnt_q == CNT_W'(CLK_DIV - 1));
        gap_done     = (cnt_q == CNT_W'(GAP_CLKS - 1));

        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                sclk_d = 1'b0;
                if (req0 | req1) begin
                    state_d      = SETUP;
                    last_grant_d = pick;
                    tx_sr_d      = wsel;
                    mosi_d       = wsel[DATA_LENGTH-1];
                    rx_sr_d      = '0;
                    bit_cnt_d    = '0;
                    ss_d         = 1'b0;
                    busy_d       = 1'b1;
                end
            end
            SETUP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (half_done) begin
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (half_done) begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d    = 1'b1;
                        rx_sr_d   = {rx_sr_q[DATA_LENGTH-2:0], miso_s2};
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_cnt_q < BIT_W'(DATA_LENGTH)) begin
                            tx_sr_d = tx_sr_q << 1;
                            mosi_d  = tx_sr_q[DATA_LENGTH-2];
                        end else begin
                            state_d = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (half_done) begin
                    cnt_d   = '0;
                    ss_d    = 1'b1;
                    mosi_d  = 1'b0;
                    state_d = GAP;
                    if (last_grant_q) begin
                        rdata1_d = rx_sr_q;
                        done1_d  = 1'b1;
                    end else begin
                        rdata0_d = rx_sr_q;
                        done0_d  = 1'b1;
                    end
                end
            end
            GAP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (gap_done) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;
    assign done0  = done0_q;
    assign done1  = done1_q;
    assign busy   = busy_q;
    assign SCLK   = sclk_q;
    assign MOSI   = mosi_q;
    assign SS     = ss_q;

endmodule

// File: doc/spi_master_arbiter.md
Name: spi_master_arbiter

Overview:
- SPI master that shares one SPI link to an spi_control slave between two on-chip requesters.
- Arbitrates requests round-robin and generates SS, SCLK and MOSI from the system clock.
- Samples MISO and returns each received byte to the requester that was granted.
- Link is mode 0, MSB first: the slave samples MOSI on SCLK rise and updates MISO on SCLK fall.

Parameters:
- DATA_LENGTH, 8: bits per transaction; must match the slave.
- CLK_DIV, 4: clk cycles per SCLK half-period; legal values >= 4.
- SS_GAP, 2: minimum SS-high time between transactions, in SCLK half-periods.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0  input  1  requester 0 transaction request (level).
- wdata0  input  DATA_LENGTH  requester 0 byte to send.
- rdata0  output  DATA_LENGTH  requester 0 received byte.
- done0  output  1  requester 0 completion pulse.
- req1, wdata1, rdata1, done1: same as requester 0, for requester 1.
- busy  output  1  high while a transaction or inter-frame gap is in progress.
- SCLK  output  1  SPI clock; idles low.
- MOSI  output  1  SPI data out.
- MISO  input  1  SPI data in; asynchronous to clk.
- SS  output  1  active-low slave select.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - SS=1, SCLK=0, MOSI=0, busy=0.
  - done0=done1=0, rdata0=rdata1=0.
  - State IDLE; last_grant=1, so requester 0 wins the first tie.
- All outputs are registered. MISO passes through a 2-flop synchronizer before use.
- IDLE: SS=1, SCLK=0.
  - req0 and req1 are sampled only in this state.
  - One request high: grant that requester.
  - Both high: grant the requester that is not last_grant.
  - On grant (next edge): latch its wdata into tx_sr; SS->0; MOSI<=tx_sr MSB; busy->1; update last_grant; go to SETUP.
- SETUP: hold SCLK=0 for CLK_DIV clks, then go to SHIFT.
- SHIFT: the half-period counter toggles SCLK every CLK_DIV clks.
  - On the clk edge that drives SCLK 0->1: shift the synchronized MISO into rx_sr at the LSB; bit_cnt++.
  - On the edge that drives SCLK 1->0: if bit_cnt < DATA_LENGTH, shift tx_sr and drive the next bit on MOSI. Otherwise go to HOLD.
  - Exactly DATA_LENGTH rising SCLK edges per transaction.
- HOLD: SCLK=0, SS=0 for CLK_DIV clks. On exit, on the same edge:
  - SS->1;
  - granted rdataN<=rx_sr;
  - granted doneN=1 for exactly one clk.
  - Then go to GAP.
- GAP: SS=1 for SS_GAP*CLK_DIV clks, then IDLE; busy->0 on entry to IDLE.
- Timing: SS low for (2*DATA_LENGTH+2)*CLK_DIV clks, which is 72 clks with defaults. doneN asserts on the edge SS rises.
- Request rules:
  - wdataN is sampled only at grant.
  - Dropping reqN mid-transaction is ignored; the transaction completes and doneN still pulses.
  - reqN still high when IDLE is re-entered counts as a new request.
- Round-robin: under continuous requests from both, grants strictly alternate, with no starvation.
- rdataN holds its value until that requester's next completion. The non-granted rdata/done are untouched.
- MOSI is 0 whenever SS=1.

Test Plan:
1. Reset, then req0=1 with wdata0=0xA5; slave model returns 0x3C. Required:
   - SS low 72 clks;
   - 8 SCLK rises, CLK_DIV=4 clks high/low;
   - slave receives 0xA5;
   - rdata0=0x3C; done0 one pulse at SS rise; done1 never asserts.
2. req0 and req1 rise in the same cycle after reset (wdata0=0x11, wdata1=0x22). Required:
   - requester 0 served first, then requester 1;
   - SS high >= 8 clks between frames;
   - slave receives 0x11 then 0x22.
3. req0 and req1 held high for 4 frames. Required:
   - grant order 0,1,0,1;
   - each doneN pulses twice;
   - rdataN matches the slave model data for the corresponding frame.
4. req1 rises during requester 0's SHIFT and req0 drops mid-frame. Required:
   - frame 0 completes with done0;
   - requester 1 is granted on the first IDLE cycle after GAP.
5. rst_n pulsed low after the 3rd SCLK rise. Required:
   - SS=1 and SCLK=0 within the same cycle;
   - busy=0, rdata0=0;
   - after release, a new req0 with 0x5A completes correctly.
6. MISO toggled between SCLK falls only. Required: rdata bit order MSB-first, matching the driven pattern 0x81.
